// File: rtl/byte_print_sequencer.sv
// Feeds print8x8 one glyph at a time from a byte FIFO, tracking a wrapping text cursor.
// Outputs are registered; beginPrint is high only in ISSUE. A full FIFO drops in_ready.
module byte_print_sequencer #(
  parameter int          FIFO_DEPTH = 8,
  parameter int          CELL       = 8,
  parameter int          SCREEN_W   = 160,
  parameter int          SCREEN_H   = 120,
  parameter logic [7:0]  NL_CODE    = 8'h0A
) (
  input  logic       CLOCK_50,
  input  logic       resetN,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       clear_cursor,
  output logic [7:0] print_data,
  output logic [9:0] print_x,
  output logic [8:0] print_y,
  output logic       beginPrint,
  input  logic       donePrint,
  output logic [3:0] fifo_count,
  output logic       busy
);

  localparam int         AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] DEPTH4 = 4'(FIFO_DEPTH);
  localparam logic [9:0] X_LAST = 10'(SCREEN_W - CELL);
  localparam logic [8:0] Y_LAST = 9'(SCREEN_H - CELL);
  localparam logic [9:0] X_STEP = 10'(CELL);
  localparam logic [8:0] Y_STEP = 9'(CELL);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [3:0]    count_q, count_d;
  state_t        state_q;
  logic [9:0]    cur_x_q;
  logic [8:0]    cur_y_q;
  logic          clr_pend_q;
  logic [7:0]    pdata_q;
  logic [9:0]    px_q;
  logic [8:0]    py_q;
  logic          begin_q;
  logic          busy_q;

  logic       push, pop;
  logic [7:0] head;

  assign in_ready   = (count_q < DEPTH4);
  assign push       = in_valid && in_ready;
  // A pending clear takes the idle slot, so the pop waits one cycle behind it.
  assign pop        = (state_q == IDLE) && !clr_pend_q && (count_q != 4'd0);
  assign head       = mem_q[rd_ptr_q];

  assign print_data = pdata_q;
  assign print_x    = px_q;
  assign print_y    = py_q;
  assign beginPrint = begin_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

  function automatic logic [8:0] next_row(input logic [8:0] y);
    return (y == Y_LAST) ? 9'd0 : y + Y_STEP;
  endfunction

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (resetN && push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetN) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 4'd0;
      state_q    <= IDLE;
      cur_x_q    <= 10'd0;
      cur_y_q    <= 9'd0;
      clr_pend_q <= 1'b0;
      pdata_q    <= 8'd0;
      px_q       <= 10'd0;
      py_q       <= 9'd0;
      begin_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      begin_q    <= 1'b0;
      clr_pend_q <= clr_pend_q || clear_cursor;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);

      case (state_q)
        IDLE: begin
          if (clr_pend_q) begin
            cur_x_q    <= 10'd0;
            cur_y_q    <= 9'd0;
            clr_pend_q <= clear_cursor;
          end else if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            if (head == NL_CODE) begin
              cur_x_q <= 10'd0;
              cur_y_q <= next_row(cur_y_q);
            end else begin
              pdata_q <= head;
              px_q    <= cur_x_q;
              py_q    <= cur_y_q;
              begin_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (donePrint) begin
            if (cur_x_q == X_LAST) begin
              cur_x_q <= 10'd0;
              cur_y_q <= next_row(cur_y_q);
            end else begin
              cur_x_q <= cur_x_q + X_STEP;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
